fp_rnd_pipe: RTL and testbench

Pipelined rounding/packing stage directly downstream of the integer-to-float converter; also shared by other fp_rnd record producers. It consumes the unrounded fp_rnd record (sign, biased exponent, 25-bit mantissa, guard/round/sticky, special-case flags) and produces a packed IEEE-754 binary32 result with the 5-bit exception flags. Two register stages with a valid/ready handshake let the converter issue one operation per cycle.

---
 rtl/fp_rnd_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_fp_rnd_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rnd_pipe.sv
// Rounding/packing stage for fp_rnd records: round, normalise, pack to binary32 plus flags.
// Optional FP_RND_PIPE_FFLAGS_EN adds a sticky accumulated-flags register (fflags_o/fflags_clr_i).
module fp_rnd_pipe #(
    parameter int EXPO_W        = 10,
    parameter int STAGES_BYPASS = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sig_i,
    input  logic [EXPO_W-1:0] expo_i,
    input  logic [24:0]       mant_i,
    input  logic [2:0]        grs_i,
    input  logic [2:0]        rm_i,
    input  logic              snan_i,
    input  logic              qnan_i,
    input  logic              dbz_i,
    input  logic              inf_i,
    input  logic              zero_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       result_o,
    output logic [4:0]        flags_o
`ifdef FP_RND_PIPE_FFLAGS_EN
    ,
    output logic [4:0]        fflags_o,
    input  logic              fflags_clr_i
`endif
);

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic signed [EXPO_W:0] EXP_ONE = (EXPO_W+1)'(1);
    localparam logic signed [EXPO_W:0] EXP_OVF = (EXPO_W+1)'(255);

    typedef struct packed {
        logic              sig;
        logic [EXPO_W-1:0] expo;
        logic [24:0]       mant;
        logic              inexact;
        logic [2:0]        rm;
        logic              snan;
        logic              qnan;
        logic              dbz;
        logic              inf;
        logic              zero;
    } rnd_rec_t;

    // Stage 1: rounding increment on the incoming record.
    rnd_rec_t   rec_d;
    logic [2:0] rm_eff;
    logic       inexact_d;
    logic       inc;

    always_comb begin
        rm_eff    = (rm_i > RM_RMM) ? RM_RNE : rm_i;
        inexact_d = |grs_i;
        inc       = 1'b0;
        case (rm_eff)
            RM_RNE:  inc = grs_i[2] & (mant_i[0] | grs_i[1] | grs_i[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sig_i & inexact_d;
            RM_RUP:  inc = ~sig_i & inexact_d;
            RM_RMM:  inc = grs_i[2];
            default: inc = 1'b0;
        endcase
        rec_d.sig     = sig_i;
        rec_d.expo    = expo_i;
        rec_d.mant    = mant_i + {24'd0, inc};
        rec_d.inexact = inexact_d;
        rec_d.rm      = rm_eff;
        rec_d.snan    = snan_i;
        rec_d.qnan    = qnan_i;
        rec_d.dbz     = dbz_i;
        rec_d.inf     = inf_i;
        rec_d.zero    = zero_i;
    end

    // Handshake: a record moves into a stage on a cycle where that stage's
    // valid is high and its ready is high; valid/data never change while
    // valid is high and ready is low. ready_o = ~s1_valid | s1_advance and
    // s1_advance = ~valid_o | ready_i, so a full pipe still streams one per cycle.
    logic     s1_valid;
    logic     s1_advance;
    rnd_rec_t rec_s1;

    assign s1_advance = ~valid_o | ready_i;

    generate
        if (STAGES_BYPASS != 0) begin : g_bypass
            assign s1_valid = valid_i;
            assign rec_s1   = rec_d;
            assign ready_o  = s1_advance;
        end else begin : g_stage1
            logic     valid_q;
            rnd_rec_t rec_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    rec_q   <= '0;
                end else if (ready_o) begin
                    valid_q <= valid_i;
                    if (valid_i) begin
                        rec_q <= rec_d;
                    end
                end
            end

            assign s1_valid = valid_q;
            assign rec_s1   = rec_q;
            assign ready_o  = ~valid_q | s1_advance;
        end
    endgenerate

    // Stage 2: normalise carry-out, detect overflow/underflow, pack.
    logic signed [EXPO_W:0] e_n;
    logic [23:0]            m_n;
    logic                   ovf;
    logic                   tiny;
    logic                   to_inf;
    logic [7:0]             exp_field;
    logic [31:0]            res_d;
    logic [4:0]             flg_d;

    always_comb begin
        m_n = rec_s1.mant[24] ? rec_s1.mant[24:1] : rec_s1.mant[23:0];
        e_n = $signed({rec_s1.expo[EXPO_W-1], rec_s1.expo}) + {{EXPO_W{1'b0}}, rec_s1.mant[24]};
        if ((e_n == '0) && m_n[23]) begin
            e_n = EXP_ONE;
        end
        ovf  = (e_n >= EXP_OVF);
        tiny = (e_n < EXP_ONE) || !m_n[23];

        to_inf = 1'b0;
        case (rec_s1.rm)
            RM_RNE, RM_RMM: to_inf = 1'b1;
            RM_RUP:         to_inf = ~rec_s1.sig;
            RM_RDN:         to_inf = rec_s1.sig;
            default:        to_inf = 1'b0;
        endcase

        // A non-positive exponent can only be encoded as the subnormal field.
        exp_field = (e_n < EXP_ONE) ? 8'd0 : e_n[7:0];

        res_d = {rec_s1.sig, exp_field, m_n[22:0]};
        flg_d = {3'b000, tiny & rec_s1.inexact, rec_s1.inexact};

        if (rec_s1.snan) begin
            res_d = 32'h7FC0_0000;
            flg_d = 5'b10000;
        end else if (rec_s1.qnan) begin
            res_d = 32'h7FC0_0000;
            flg_d = 5'b00000;
        end else if (rec_s1.dbz) begin
            res_d = {rec_s1.sig, 8'hFF, 23'd0};
            flg_d = 5'b01000;
        end else if (rec_s1.inf) begin
            res_d = {rec_s1.sig, 8'hFF, 23'd0};
            flg_d = 5'b00000;
        end else if (rec_s1.zero) begin
            res_d = {rec_s1.sig, 31'd0};
            flg_d = 5'b00000;
        end else if (ovf) begin
            res_d = to_inf ? {rec_s1.sig, 8'hFF, 23'd0} : {rec_s1.sig, 31'h7F7F_FFFF};
            flg_d = 5'b00101;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_o  <= 1'b0;
            result_o <= 32'd0;
            flags_o  <= 5'd0;
        end else if (s1_advance) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                result_o <= res_d;
                flags_o  <= flg_d;
            end
        end
    end

`ifdef FP_RND_PIPE_FFLAGS_EN
    // Clear takes precedence over a flag set arriving in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fflags_o <= 5'd0;
        end else if (fflags_clr_i) begin
            fflags_o <= 5'd0;
        end else if (valid_o && ready_i) begin
            fflags_o <= fflags_o | flags_o;
        end
    end
`endif

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe: vector table through a scoreboard plus
// hand sequences for latency, backpressure and reset mid-flight.
module tb_fp_rnd_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sig_i = 1'b0;
    logic [9:0]  expo_i = 10'd0;
    logic [24:0] mant_i = 25'd0;
    logic [2:0]  grs_i = 3'd0;
    logic [2:0]  rm_i = 3'd0;
    logic        snan_i = 1'b0;
    logic        qnan_i = 1'b0;
    logic        dbz_i = 1'b0;
    logic        inf_i = 1'b0;
    logic        zero_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
`ifdef FP_RND_PIPE_FFLAGS_EN
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 1'b0;
    logic [4:0]  acc_flg = 5'd0;
`endif

    fp_rnd_pipe dut (
        .clock    (clock),
        .reset    (reset),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sig_i    (sig_i),
        .expo_i   (expo_i),
        .mant_i   (mant_i),
        .grs_i    (grs_i),
        .rm_i     (rm_i),
        .snan_i   (snan_i),
        .qnan_i   (qnan_i),
        .dbz_i    (dbz_i),
        .inf_i    (inf_i),
        .zero_i   (zero_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .flags_o  (flags_o)
`ifdef FP_RND_PIPE_FFLAGS_EN
        ,
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i)
`endif
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    typedef struct {
        logic        sig;
        logic [9:0]  expo;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [4:0]  spec;   // {snan, qnan, dbz, inf, zero}
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    logic [36:0] exp_q[$];
    int total = 0;
    int bad = 0;
    logic tbl_done = 1'b0;

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [24:0] m,
                                input logic [2:0] g, input logic [2:0] r, input logic [4:0] sp,
                                input logic [31:0] res, input logic [4:0] flg);
        vec_t v;
        v.sig = s; v.expo = e; v.mant = m; v.grs = g; v.rm = r; v.spec = sp;
        v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: a transfer occurs on the next rising edge when both are high.
    always @(negedge clock) begin
        if (reset && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h/%b want none", result_o, flags_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("result", result_o, e[36:5]);
                check("flags", 32'(flags_o), 32'(e[4:0]));
`ifdef FP_RND_PIPE_FFLAGS_EN
                acc_flg = acc_flg | e[4:0];
`endif
            end
        end
    end

    // Driver: entered and left at posedge+1; valid_i stays high on return.
    task automatic drive(input vec_t v);
        int n;
        valid_i = 1'b1;
        sig_i = v.sig; expo_i = v.expo; mant_i = v.mant; grs_i = v.grs; rm_i = v.rm;
        {snan_i, qnan_i, dbz_i, inf_i, zero_i} = v.spec;
        n = 0;
        @(negedge clock);
        while (!ready_o && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("accept_in_time", 32'(ready_o), 32'd1);
        if (ready_o) exp_q.push_back({v.res, v.flg});
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00000, 32'h3F800000, 5'b00000);
        vecs[1]  = mk(1'b0, 10'd127, 25'h0FFFFFF, 3'b100, 3'd0, 5'b00000, 32'h40000000, 5'b00001);
        vecs[2]  = mk(1'b0, 10'd254, 25'h0FFFFFF, 3'b111, 3'd1, 5'b00000, 32'h7F7FFFFF, 5'b00001);
        vecs[3]  = mk(1'b0, 10'd254, 25'h0FFFFFF, 3'b111, 3'd0, 5'b00000, 32'h7F800000, 5'b00101);
        vecs[4]  = mk(1'b1, 10'd5,   25'h0123456, 3'b111, 3'd3, 5'b10000, 32'h7FC00000, 5'b10000);
        vecs[5]  = mk(1'b1, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00100, 32'hFF800000, 5'b01000);
        vecs[6]  = mk(1'b0, 10'd127, 25'h0800000, 3'b010, 3'd0, 5'b01000, 32'h7FC00000, 5'b00000);
        vecs[7]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b00010, 32'h7F800000, 5'b00000);
        vecs[8]  = mk(1'b1, 10'd127, 25'h0800000, 3'b111, 3'd0, 5'b00001, 32'h80000000, 5'b00000);
        vecs[9]  = mk(1'b0, 10'd127, 25'h0800000, 3'b000, 3'd0, 5'b11100, 32'h7FC00000, 5'b10000);
        vecs[10] = mk(1'b0, 10'd127, 25'h0800000, 3'b100, 3'd0, 5'b00000, 32'h3F800000, 5'b00001);
        vecs[11] = mk(1'b0, 10'd127, 25'h0800001, 3'b100, 3'd0, 5'b00000, 32'h3F800002, 5'b00001);
        vecs[12] = mk(1'b1, 10'd127, 25'h0800000, 3'b001, 3'd2, 5'b00000, 32'hBF800001, 5'b00001);
        vecs[13] = mk(1'b0, 10'd127, 25'h0800000, 3'b001, 3'd2, 5'b00000, 32'h3F800000, 5'b00001);
        vecs[14] = mk(1'b0, 10'd127, 25'h0800000, 3'b001, 3'd3, 5'b00000, 32'h3F800001, 5'b00001);
        vecs[15] = mk(1'b0, 10'd127, 25'h0800000, 3'b100, 3'd4, 5'b00000, 32'h3F800001, 5'b00001);
        vecs[16] = mk(1'b0, 10'd127, 25'h0800001, 3'b100, 3'd7, 5'b00000, 32'h3F800002, 5'b00001);
        vecs[17] = mk(1'b1, 10'd255, 25'h0800000, 3'b000, 3'd1, 5'b00000, 32'hFF7FFFFF, 5'b00101);
        vecs[18] = mk(1'b1, 10'd300, 25'h0800000, 3'b000, 3'd3, 5'b00000, 32'hFF7FFFFF, 5'b00101);
        vecs[19] = mk(1'b1, 10'd300, 25'h0800000, 3'b000, 3'd2, 5'b00000, 32'hFF800000, 5'b00101);
        vecs[20] = mk(1'b0, 10'd0,   25'h0400000, 3'b000, 3'd0, 5'b00000, 32'h00400000, 5'b00000);
        vecs[21] = mk(1'b0, 10'd0,   25'h0400000, 3'b001, 3'd0, 5'b00000, 32'h00400000, 5'b00011);
        vecs[22] = mk(1'b0, 10'd0,   25'h07FFFFF, 3'b100, 3'd0, 5'b00000, 32'h00800000, 5'b00001);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_result_o", result_o, 32'd0);
        check("rst_flags_o", 32'(flags_o), 32'd0);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        @(posedge clock);
        #1;

        // Latency: valid_o rises exactly two cycles after the accepting edge.
        drive(vecs[0]);
        valid_i = 1'b0;
        @(negedge clock);
        check("lat_cycle1_valid", 32'(valid_o), 32'd0);
        @(negedge clock);
        check("lat_cycle2_valid", 32'(valid_o), 32'd1);
        drain();

        // Table with random backpressure and idle gaps.
        fork
            begin
                for (int i = 0; i < NVEC; i++) begin
                    drive(vecs[i]);
                    if ($urandom_range(0, 3) == 0) begin
                        valid_i = 1'b0;
                        @(posedge clock);
                        #1;
                    end
                end
                valid_i = 1'b0;
                tbl_done = 1'b1;
            end
            begin
                while (!tbl_done) begin
                    @(posedge clock);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        // Four back-to-back with ready_i held low for three cycles.
        fork
            begin
                for (int k = 1; k <= 4; k++) drive(vecs[k]);
                valid_i = 1'b0;
            end
            begin
                ready_i = 1'b0;
                repeat (3) @(negedge clock);
                check("bp_ready_o_low", 32'(ready_o), 32'd0);
                check("bp_valid_o_high", 32'(valid_o), 32'd1);
                @(posedge clock);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

`ifdef FP_RND_PIPE_FFLAGS_EN
        check("fflags_sticky", 32'(fflags_o), 32'(acc_flg));
        fflags_clr_i = 1'b1;
        @(posedge clock);
        #1;
        fflags_clr_i = 1'b0;
        check("fflags_cleared", 32'(fflags_o), 32'd0);
`endif

        // Reset with two records in flight.
        drive(vecs[1]);
        drive(vecs[3]);
        valid_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_result_o", result_o, 32'd0);
        check("midrst_flags_o", 32'(flags_o), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        drive(vecs[12]);
        valid_i = 1'b0;
        @(negedge clock);
        check("postrst_cycle1_valid", 32'(valid_o), 32'd0);
        @(negedge clock);
        check("postrst_cycle2_valid", 32'(valid_o), 32'd1);
        drain();
        repeat (5) @(posedge clock);
        #1;
        check("postrst_idle_valid", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
